gac_pla_and_plane_pipe: RTL
===========================

Name: gac_pla_and_plane_pipe

Overview:
- Parametrised, pipelined AND plane for the control-decode PLA; replaces fixed-width combinational AND gates with N_TERMS programmable product terms over N_IN inputs.
- Each term has a per-input care mask and polarity mask, plus an enable bit, loaded through a write port.
- Two-stage valid/ready pipeline between the instruction-decode input register and the control-signal consumers.

Parameters:
- N_IN, 6, number of PLA inputs (>=2)
- N_TERMS, 8, number of product terms (>=1)
- GROUP, 2, inputs ANDed per stage-A partial group; N_GRP = ceil(N_IN/GROUP)
- N_OUT, 4, OR-plane outputs (used only with GAC_PLA_OR_PLANE_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  N_IN  PLA input literals
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- terms  out  N_TERMS  product-term results
- prog_we  in  1  term-mask write strobe
- prog_term  in  clog2(N_TERMS) (min 1)  term index
- prog_care  in  N_IN  1 = input participates
- prog_pol  in  N_IN  1 = true literal, 0 = complemented
- prog_en  in  1  term enable
- prog_or_we  in  1  OR-mask write strobe (macro only)
- prog_or_idx  in  clog2(N_OUT) (min 1)  OR output index (macro only)
- prog_or_mask  in  N_TERMS  terms feeding that output (macro only)
- z_or  out  N_OUT  OR-plane outputs (macro only)

Behaviour:
- Reset is asynchronous and active-high: care, pol, en, and the stage registers (vA, vB, partials, terms) clear to 0. After reset, out_valid=0, terms=0, and in_ready=1.
- Literal: lit[i] = in_data[i] XNOR pol[t][i]. A masked input contributes 1: m[i] = lit[i] | ~care[t][i].
- Stage A: on acceptance, register part[t][g] = AND of m over group g. The last group is padded with 1. Set vA=1.
- Stage B: register terms[t] = en[t] & AND of part[t][*]. Set vB=1.
- Latency: 2 cycles from accepted input to out_valid with no stalls. Throughput is 1 per cycle.
- Handshake:
  - advB = !vB | out_ready
  - advA = vA & advB
  - in_ready = !vA | advB
  - Input is accepted when in_valid & in_ready.
  - vA next = accept | (vA & !advB)
  - vB next = advA | (vB & !out_ready)
  - When out_ready=0 and vB=1, terms and out_valid hold stable.
- Full: with vA=vB=1 and out_ready=0, in_ready=0 and the contents of both stages hold.
- Empty: terms hold their last value while out_valid=0.
- Mask write timing:
  - prog_we updates care, pol and en of prog_term at the clock edge.
  - Inputs accepted in the same cycle use the old mask; inputs accepted later use the new one.
  - Data already in stage A or B is unaffected, except that en is applied at the A→B transfer. An item already in stage A when en changes uses the new en.
- A prog_term index >= N_TERMS is ignored.
- An empty care mask with en=1 gives term=1.
- Reset asserted mid-stream discards in-flight data immediately. Masks clear, so every term must be reprogrammed afterwards.

Optional Feature:
- Macro: GAC_PLA_OR_PLANE_EN.
- Defined:
  - Adds the prog_or_* ports and z_or.
  - The OR mask for each output resets to 0; a write takes effect at the edge.
  - z_or[k] = OR over t of (terms[t] & ormask[k][t]), combinational from the stage-B register. It is valid with out_valid, so latency is unchanged.
  - A prog_or_idx >= N_OUT is ignored.
- Not defined: these ports and that logic are absent, and the block is the AND plane only.

Decomposition:
- Package gac_pla_pkg holds:
  - the default parameter constants
  - a clog2 helper function
  - the literal-mask typedef (care, pol, en).
- One sub-module, gac_and_group: a parametrised GROUP-wide masked AND. It is instantiated per term and per group in stage A, and reused for the stage-B reduction.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle → out_valid=0, terms=0, in_ready=1 immediately with no clock needed.
- Program term 0 with care=6'b111111, pol=6'b101010, en=1. Drive in_data=6'b101010 → terms[0]=1 two cycles later; in_data=6'b101011 → terms[0]=0.
- Program term 3 with care=6'b000011, pol=6'b000001, en=1. Drive in_data=6'bxxxx01 for several upper values → terms[3]=1 in every case. Term 5 unprogrammed (en=0) → terms[5]=0.
- Back-pressure: stream 4 words with out_ready=0 → in_ready drops after 2 accepts and terms hold. Release out_ready → words 1-4 emerge in order, one per cycle, with no loss or duplication.
- Mask write while flowing: reprogram term 0 pol in the same cycle as accepting word W → W uses the old mask, W+1 uses the new one.
- With GAC_PLA_OR_PLANE_EN: ormask[1]=8'b00001001 and terms 0 and 3 as programmed above → z_or[1]=1 whenever terms[0] or terms[3] is 1, aligned with out_valid.

Source files
------------

// File: rtl/gac_pla_pkg.sv
// Shared constants, index-width helper and literal-mask type for the PLA AND plane.
// No logic, so there is no latency or backpressure behaviour.
// Optional OR-plane build switch consumed by the top: GAC_PLA_OR_PLANE_EN.
package gac_pla_pkg;

    localparam int N_IN_DEF    = 6;
    localparam int N_TERMS_DEF = 8;
    localparam int GROUP_DEF   = 2;
    localparam int N_OUT_DEF   = 4;

    // Index width for n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Per-input literal control; the per-term enable is stored alongside these.
    typedef struct packed {
        logic care;
        logic pol;
    } lit_mask_t;

endpackage

// File: rtl/gac_and_group.sv
// Masked AND over W bits: a bit with care=0 contributes 1.
// Purely combinational, no handshake.
module gac_and_group #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] care,
    output logic         y
);

    assign y = &(a | ~care);

endmodule

// File: rtl/gac_pla_and_plane_pipe.sv
// Programmable PLA AND plane, optional OR plane under GAC_PLA_OR_PLANE_EN.
// Latency 2 cycles accept-to-out_valid, one word per cycle throughput.
// Valid/ready: in_ready drops only when both stages are full and out_ready is low.
module gac_pla_and_plane_pipe
    import gac_pla_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int GROUP   = GROUP_DEF,
    parameter int N_OUT   = N_OUT_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_IN-1:0]                    in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    input  logic                               prog_we,
    input  logic [clog2_min1(N_TERMS)-1:0]     prog_term,
    input  logic [N_IN-1:0]                    prog_care,
    input  logic [N_IN-1:0]                    prog_pol,
    input  logic                               prog_en,
`ifdef GAC_PLA_OR_PLANE_EN
    input  logic                               prog_or_we,
    input  logic [clog2_min1(N_OUT)-1:0]       prog_or_idx,
    input  logic [N_TERMS-1:0]                 prog_or_mask,
    output logic [N_OUT-1:0]                   z_or,
`endif
    output logic [N_TERMS-1:0]                 terms
);

    localparam int N_GRP = (N_IN + GROUP - 1) / GROUP;
    localparam int NP    = N_GRP * GROUP;

    lit_mask_t          mask_q [N_TERMS][N_IN];
    logic [N_TERMS-1:0] en_q;

    logic               va_q;
    logic               vb_q;
    logic [N_GRP-1:0]   part_q [N_TERMS];
    logic [N_TERMS-1:0] terms_q;

    logic [N_GRP-1:0]   part_d [N_TERMS];
    logic [N_TERMS-1:0] term_and;

    logic adv_a;
    logic adv_b;
    logic accept;

    assign adv_b     = !vb_q | out_ready;
    assign adv_a     = va_q & adv_b;
    assign in_ready  = !va_q | adv_b;
    assign accept    = in_valid & in_ready;
    assign out_valid = vb_q;
    assign terms     = terms_q;

    for (genvar t = 0; t < N_TERMS; t++) begin : g_term
        logic [NP-1:0]    lit_v;
        logic [NP-1:0]    care_v;
        logic [N_GRP-1:0] grp_y;

        // Pad bits beyond N_IN are don't-care so the last group reduces cleanly.
        for (genvar i = 0; i < NP; i++) begin : g_bit
            if (i < N_IN) begin : g_real
                assign lit_v[i]  = in_data[i] ~^ mask_q[t][i].pol;
                assign care_v[i] = mask_q[t][i].care;
            end else begin : g_pad
                assign lit_v[i]  = 1'b1;
                assign care_v[i] = 1'b0;
            end
        end

        for (genvar g = 0; g < N_GRP; g++) begin : g_grp
            gac_and_group #(.W(GROUP)) u_grp (
                .a    (lit_v[g*GROUP +: GROUP]),
                .care (care_v[g*GROUP +: GROUP]),
                .y    (grp_y[g])
            );
        end

        assign part_d[t] = grp_y;

        gac_and_group #(.W(N_GRP)) u_red (
            .a    (part_q[t]),
            .care ({N_GRP{1'b1}}),
            .y    (term_and[t])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va_q    <= 1'b0;
            vb_q    <= 1'b0;
            terms_q <= '0;
            for (int t = 0; t < N_TERMS; t++) begin
                part_q[t] <= '0;
            end
        end else begin
            va_q <= accept | (va_q & !adv_b);
            vb_q <= adv_a | (vb_q & !out_ready);
            if (accept) begin
                for (int t = 0; t < N_TERMS; t++) begin
                    part_q[t] <= part_d[t];
                end
            end
            // Enable is sampled at the A->B move, so a late en write still applies.
            if (adv_a) begin
                terms_q <= en_q & term_and;
            end
        end
    end

    // Out-of-range term indices match no loop iteration and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
            for (int t = 0; t < N_TERMS; t++) begin
                for (int i = 0; i < N_IN; i++) begin
                    mask_q[t][i] <= '0;
                end
            end
        end else if (prog_we) begin
            for (int t = 0; t < N_TERMS; t++) begin
                if (int'(prog_term) == t) begin
                    en_q[t] <= prog_en;
                    for (int i = 0; i < N_IN; i++) begin
                        mask_q[t][i].care <= prog_care[i];
                        mask_q[t][i].pol  <= prog_pol[i];
                    end
                end
            end
        end
    end

`ifdef GAC_PLA_OR_PLANE_EN
    logic [N_TERMS-1:0] ormask_q [N_OUT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                ormask_q[k] <= '0;
            end
        end else if (prog_or_we) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (int'(prog_or_idx) == k) begin
                    ormask_q[k] <= prog_or_mask;
                end
            end
        end
    end

    // Driven from the stage-B register so it lines up with out_valid.
    always_comb begin
        z_or = '0;
        for (int k = 0; k < N_OUT; k++) begin
            z_or[k] = |(terms_q & ormask_q[k]);
        end
    end
`endif

endmodule
